// File: rtl/rv32_decode_execute_stage_if.sv
// Bus between fetch/register-read logic and the RV32I decode/execute stage.
// The consumer side is the slave modport; the producer/observer side is master.
interface rv32_decode_execute_stage_if;
    logic        i_en;
    logic [31:0] instruction;
    logic [31:0] operand1_pi;
    logic [31:0] operand2_pi;
    logic [31:0] pc_i;

    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  fun3_o;
    logic [6:0]  fun7_o;
    logic [6:0]  opcode_o;
    logic [31:0] imm_o;
    logic [63:0] Single_Instruction_o;
    logic [6:0]  INST_typ_o;
    logic [3:0]  operand_amt_o;
    logic [31:0] alu_result_1;
    logic [31:0] alu_result_2;
    logic        branch_inst_wire;
    logic        jump_inst_wire;
    logic        write_reg_file_wire;

    modport slave (
        input  i_en, instruction, operand1_pi, operand2_pi, pc_i,
        output rd_o, rs1_o, rs2_o, fun3_o, fun7_o, opcode_o, imm_o,
               Single_Instruction_o, INST_typ_o, operand_amt_o,
               alu_result_1, alu_result_2, branch_inst_wire, jump_inst_wire,
               write_reg_file_wire
    );

    modport master (
        output i_en, instruction, operand1_pi, operand2_pi, pc_i,
        input  rd_o, rs1_o, rs2_o, fun3_o, fun7_o, opcode_o, imm_o,
               Single_Instruction_o, INST_typ_o, operand_amt_o,
               alu_result_1, alu_result_2, branch_inst_wire, jump_inst_wire,
               write_reg_file_wire
    );
endinterface

// File: rtl/rv32_decode_execute_stage.sv
// Two-stage RV32I decode + execute. Define RV_M_EXT_EN to add the M extension
// (MUL/DIV/REM family, single-cycle); otherwise those encodings decode as illegal.
module rv32_decode_execute_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    rv32_decode_execute_stage_if.slave    bus
);
    localparam int unsigned SI_W  = 64;
    localparam int unsigned TYP_W = 7;
    localparam int unsigned AMT_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [TYP_W-1:0] TYP_R   = 7'b0000001;
    localparam logic [TYP_W-1:0] TYP_I   = 7'b0000010;
    localparam logic [TYP_W-1:0] TYP_S   = 7'b0000100;
    localparam logic [TYP_W-1:0] TYP_B   = 7'b0001000;
    localparam logic [TYP_W-1:0] TYP_U   = 7'b0010000;
    localparam logic [TYP_W-1:0] TYP_J   = 7'b0100000;
    localparam logic [TYP_W-1:0] TYP_ILL = 7'b1000000;

    // operand_amt: bit0 rs1, bit1 rs2, bit2 imm, bit3 rd
    localparam logic [AMT_W-1:0] AMT_U  = 4'b1100;
    localparam logic [AMT_W-1:0] AMT_I  = 4'b1101;
    localparam logic [AMT_W-1:0] AMT_SB = 4'b0111;
    localparam logic [AMT_W-1:0] AMT_R  = 4'b1011;

    // Values equal the Single_Instruction_o bit positions.
    typedef enum logic [5:0] {
        OP_LUI = 6'd0, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins = bus.instruction;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    logic             dec_valid;
    op_e              dec_op;
    logic [TYP_W-1:0] dec_typ;
    logic [AMT_W-1:0] dec_amt;
    logic [XLEN-1:0]  dec_imm;

    // Instruction classification; anything not matched falls back to illegal.
    always_comb begin
        dec_valid = 1'b0;
        dec_op    = OP_LUI;
        dec_typ   = TYP_ILL;
        dec_amt   = '0;
        dec_imm   = '0;
        case (opc)
            OPC_LUI:   begin dec_valid = 1'b1; dec_op = OP_LUI;   dec_typ = TYP_U; dec_amt = AMT_U; dec_imm = imm_u; end
            OPC_AUIPC: begin dec_valid = 1'b1; dec_op = OP_AUIPC; dec_typ = TYP_U; dec_amt = AMT_U; dec_imm = imm_u; end
            OPC_JAL:   begin dec_valid = 1'b1; dec_op = OP_JAL;   dec_typ = TYP_J; dec_amt = AMT_U; dec_imm = imm_j; end
            OPC_JALR: begin
                dec_valid = (f3 == 3'd0); dec_op = OP_JALR; dec_typ = TYP_I; dec_amt = AMT_I; dec_imm = imm_i;
            end
            OPC_BRANCH: begin
                dec_valid = 1'b1; dec_typ = TYP_B; dec_amt = AMT_SB; dec_imm = imm_b;
                case (f3)
                    3'd0:    dec_op = OP_BEQ;
                    3'd1:    dec_op = OP_BNE;
                    3'd4:    dec_op = OP_BLT;
                    3'd5:    dec_op = OP_BGE;
                    3'd6:    dec_op = OP_BLTU;
                    3'd7:    dec_op = OP_BGEU;
                    default: dec_valid = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_valid = 1'b1; dec_typ = TYP_I; dec_amt = AMT_I; dec_imm = imm_i;
                case (f3)
                    3'd0:    dec_op = OP_LB;
                    3'd1:    dec_op = OP_LH;
                    3'd2:    dec_op = OP_LW;
                    3'd4:    dec_op = OP_LBU;
                    3'd5:    dec_op = OP_LHU;
                    default: dec_valid = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_valid = 1'b1; dec_typ = TYP_S; dec_amt = AMT_SB; dec_imm = imm_s;
                case (f3)
                    3'd0:    dec_op = OP_SB;
                    3'd1:    dec_op = OP_SH;
                    3'd2:    dec_op = OP_SW;
                    default: dec_valid = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec_valid = 1'b1; dec_typ = TYP_I; dec_amt = AMT_I; dec_imm = imm_i;
                case (f3)
                    3'd0: dec_op = OP_ADDI;
                    3'd2: dec_op = OP_SLTI;
                    3'd3: dec_op = OP_SLTIU;
                    3'd4: dec_op = OP_XORI;
                    3'd6: dec_op = OP_ORI;
                    3'd7: dec_op = OP_ANDI;
                    3'd1: begin dec_op = OP_SLLI; dec_valid = (f7 == 7'b0000000); end
                    default: begin
                        dec_op    = (f7[5]) ? OP_SRAI : OP_SRLI;
                        dec_valid = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                dec_valid = 1'b1; dec_typ = TYP_R; dec_amt = AMT_R;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0:    dec_op = OP_ADD;
                        3'd1:    dec_op = OP_SLL;
                        3'd2:    dec_op = OP_SLT;
                        3'd3:    dec_op = OP_SLTU;
                        3'd4:    dec_op = OP_XOR;
                        3'd5:    dec_op = OP_SRL;
                        3'd6:    dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                    dec_op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                    dec_op = OP_SRA;
`ifdef RV_M_EXT_EN
                end else if (f7 == 7'b0000001) begin
                    dec_op = op_e'(6'(OP_MUL) + 6'(f3));
`endif
                end else begin
                    dec_valid = 1'b0;
                end
            end
            OPC_FENCE: begin
                dec_valid = (f3 == 3'd0); dec_op = OP_FENCE; dec_typ = TYP_I; dec_imm = imm_i;
            end
            OPC_SYSTEM: begin
                dec_typ = TYP_I; dec_imm = imm_i;
                if (ins[31:7] == 25'd0) begin
                    dec_valid = 1'b1; dec_op = OP_ECALL;
                end else if (ins[31:20] == 12'd1 && ins[19:7] == 13'd0) begin
                    dec_valid = 1'b1; dec_op = OP_EBREAK;
                end
            end
            default: ;
        endcase
        if (!dec_valid) begin
            dec_typ = TYP_ILL;
            dec_amt = '0;
            dec_imm = '0;
        end
    end

    logic [4:0]       d_rd, d_rs1, d_rs2;
    logic [2:0]       d_f3;
    logic [6:0]       d_f7, d_opc;
    logic [XLEN-1:0]  d_imm;
    logic [SI_W-1:0]  d_single;
    logic [TYP_W-1:0] d_typ;
    logic [AMT_W-1:0] d_amt;
    logic             d_valid;
    op_e              d_op;

    // Decode stage register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d_rd <= '0; d_rs1 <= '0; d_rs2 <= '0; d_f3 <= '0; d_f7 <= '0; d_opc <= '0;
            d_imm <= '0; d_single <= '0; d_typ <= '0; d_amt <= '0;
            d_valid <= 1'b0; d_op <= OP_LUI;
        end else if (bus.i_en) begin
            d_rd     <= ins[11:7];
            d_rs1    <= ins[19:15];
            d_rs2    <= ins[24:20];
            d_f3     <= f3;
            d_f7     <= f7;
            d_opc    <= opc;
            d_imm    <= dec_imm;
            d_single <= dec_valid ? (SI_W'(1) << dec_op) : '0;
            d_typ    <= dec_typ;
            d_amt    <= dec_amt;
            d_valid  <= dec_valid;
            d_op     <= dec_op;
        end
    end

    logic [XLEN-1:0] op1, op2, pc;
    assign op1 = bus.operand1_pi;
    assign op2 = bus.operand2_pi;
    assign pc  = bus.pc_i;

`ifdef RV_M_EXT_EN
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   sdiv_b, udiv_b, sdiv_q, sdiv_r, udiv_q, udiv_r;

    // Sign/zero extension picks MULH/MULHSU/MULHU; the low half is correct for MUL either way.
    assign mul_a = {{XLEN{op1[XLEN-1] & (d_op != OP_MULHU)}}, op1};
    assign mul_b = {{XLEN{op2[XLEN-1] & (d_op == OP_MUL || d_op == OP_MULH)}}, op2};
    assign prod  = mul_a * mul_b;

    // Divisors are forced to 1 in the special cases so the dividers never see /0 or overflow.
    assign div_zero = (op2 == '0);
    assign div_ovf  = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign sdiv_b   = (div_zero || div_ovf) ? XLEN'(1) : op2;
    assign udiv_b   = div_zero ? XLEN'(1) : op2;
    assign sdiv_q   = XLEN'($signed(op1) / $signed(sdiv_b));
    assign sdiv_r   = XLEN'($signed(op1) % $signed(sdiv_b));
    assign udiv_q   = op1 / udiv_b;
    assign udiv_r   = op1 % udiv_b;
`endif

    logic [XLEN-1:0] x_res1, x_res2;
    logic            x_br, x_jmp, x_wr, is_branch, take;

    // Execute datapath
    always_comb begin
        x_res1    = '0;
        x_res2    = '0;
        x_jmp     = 1'b0;
        is_branch = 1'b0;
        take      = 1'b0;
        if (d_valid) begin
            case (d_op)
                OP_LUI:   x_res1 = d_imm;
                OP_AUIPC: x_res1 = pc + d_imm;
                OP_JAL:   begin x_res1 = pc + XLEN'(4); x_res2 = pc + d_imm; x_jmp = 1'b1; end
                OP_JALR:  begin x_res1 = pc + XLEN'(4); x_res2 = (op1 + d_imm) & ~XLEN'(1); x_jmp = 1'b1; end
                OP_BEQ:   begin is_branch = 1'b1; take = (op1 == op2); end
                OP_BNE:   begin is_branch = 1'b1; take = (op1 != op2); end
                OP_BLT:   begin is_branch = 1'b1; take = ($signed(op1) <  $signed(op2)); end
                OP_BGE:   begin is_branch = 1'b1; take = ($signed(op1) >= $signed(op2)); end
                OP_BLTU:  begin is_branch = 1'b1; take = (op1 <  op2); end
                OP_BGEU:  begin is_branch = 1'b1; take = (op1 >= op2); end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: x_res1 = op1 + d_imm;
                OP_SB, OP_SH, OP_SW: begin x_res1 = op1 + d_imm; x_res2 = op2; end
                OP_ADDI:  x_res1 = op1 + d_imm;
                OP_SLTI:  x_res1 = XLEN'($signed(op1) < $signed(d_imm));
                OP_SLTIU: x_res1 = XLEN'(op1 < d_imm);
                OP_XORI:  x_res1 = op1 ^ d_imm;
                OP_ORI:   x_res1 = op1 | d_imm;
                OP_ANDI:  x_res1 = op1 & d_imm;
                OP_SLLI:  x_res1 = op1 << d_imm[4:0];
                OP_SRLI:  x_res1 = op1 >> d_imm[4:0];
                OP_SRAI:  x_res1 = XLEN'($signed(op1) >>> d_imm[4:0]);
                OP_ADD:   x_res1 = op1 + op2;
                OP_SUB:   x_res1 = op1 - op2;
                OP_SLL:   x_res1 = op1 << op2[4:0];
                OP_SLT:   x_res1 = XLEN'($signed(op1) < $signed(op2));
                OP_SLTU:  x_res1 = XLEN'(op1 < op2);
                OP_XOR:   x_res1 = op1 ^ op2;
                OP_SRL:   x_res1 = op1 >> op2[4:0];
                OP_SRA:   x_res1 = XLEN'($signed(op1) >>> op2[4:0]);
                OP_OR:    x_res1 = op1 | op2;
                OP_AND:   x_res1 = op1 & op2;
`ifdef RV_M_EXT_EN
                OP_MUL:   x_res1 = prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: x_res1 = prod[2*XLEN-1:XLEN];
                OP_DIV:   x_res1 = div_zero ? '1  : (div_ovf ? op1 : sdiv_q);
                OP_REM:   x_res1 = div_zero ? op1 : (div_ovf ? '0  : sdiv_r);
                OP_DIVU:  x_res1 = div_zero ? '1  : udiv_q;
                OP_REMU:  x_res1 = div_zero ? op1 : udiv_r;
`endif
                default: ;
            endcase
        end
        if (is_branch) begin
            x_res1 = XLEN'(take);
            x_res2 = pc + d_imm;
        end
        x_br = is_branch & take;
        x_wr = d_amt[3] & (d_rd != 5'd0);
    end

    logic [XLEN-1:0] e_res1, e_res2;
    logic            e_br, e_jmp, e_wr;

    // Execute stage register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            e_res1 <= '0; e_res2 <= '0; e_br <= 1'b0; e_jmp <= 1'b0; e_wr <= 1'b0;
        end else if (bus.i_en) begin
            e_res1 <= x_res1;
            e_res2 <= x_res2;
            e_br   <= x_br;
            e_jmp  <= x_jmp;
            e_wr   <= x_wr;
        end
    end

    assign bus.rd_o                 = d_rd;
    assign bus.rs1_o                = d_rs1;
    assign bus.rs2_o                = d_rs2;
    assign bus.fun3_o               = d_f3;
    assign bus.fun7_o               = d_f7;
    assign bus.opcode_o             = d_opc;
    assign bus.imm_o                = d_imm;
    assign bus.Single_Instruction_o = d_single;
    assign bus.INST_typ_o           = d_typ;
    assign bus.operand_amt_o        = d_amt;
    assign bus.alu_result_1         = e_res1;
    assign bus.alu_result_2         = e_res2;
    assign bus.branch_inst_wire     = e_br;
    assign bus.jump_inst_wire       = e_jmp;
    assign bus.write_reg_file_wire  = e_wr;
endmodule

// File: tb/tb_rv32_decode_execute_stage.sv
// Directed bench for rv32_decode_execute_stage: hand-encoded instructions with
// hand-computed decode and execute results, plus reset and hold behaviour.
module tb_rv32_decode_execute_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rv32_decode_execute_stage_if bus ();

    rv32_decode_execute_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [31:0] ins);
        bus.instruction = ins;
        step();
    endtask

    task automatic exe(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] pc);
        bus.operand1_pi = o1;
        bus.operand2_pi = o2;
        bus.pc_i        = pc;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_en        = 1'b0;
        bus.instruction = 32'h0;
        bus.operand1_pi = 32'h0;
        bus.operand2_pi = 32'h0;
        bus.pc_i        = 32'h0;
        repeat (2) step();
        check("rst_single", bus.Single_Instruction_o, 64'h0);
        check("rst_typ",    64'(bus.INST_typ_o), 64'h0);
        check("rst_alu1",   64'(bus.alu_result_1), 64'h0);
        check("rst_wr",     64'(bus.write_reg_file_wire), 64'h0);
        rst = 1'b0;
        bus.i_en = 1'b1;

        // ADDI x5,x1,-3
        dec(32'hFFD08293);
        check("addi_rd",     64'(bus.rd_o), 64'd5);
        check("addi_rs1",    64'(bus.rs1_o), 64'd1);
        check("addi_opcode", 64'(bus.opcode_o), 64'h13);
        check("addi_imm",    64'(bus.imm_o), 64'hFFFFFFFD);
        check("addi_single", bus.Single_Instruction_o, 64'h1 << 18);
        check("addi_typ",    64'(bus.INST_typ_o), 64'h02);
        check("addi_amt",    64'(bus.operand_amt_o), 64'hD);
        exe(32'd10, 32'd0, 32'd0);
        check("addi_alu1", 64'(bus.alu_result_1), 64'd7);
        check("addi_alu2", 64'(bus.alu_result_2), 64'd0);
        check("addi_wr",   64'(bus.write_reg_file_wire), 64'd1);

        // SUB x3,x1,x2
        dec(32'h402081B3);
        check("sub_single", bus.Single_Instruction_o, 64'h1 << 28);
        check("sub_typ",    64'(bus.INST_typ_o), 64'h01);
        check("sub_amt",    64'(bus.operand_amt_o), 64'hB);
        check("sub_fun7",   64'(bus.fun7_o), 64'h20);
        exe(32'd5, 32'd9, 32'd0);
        check("sub_alu1", 64'(bus.alu_result_1), 64'hFFFFFFFC);
        check("sub_wr",   64'(bus.write_reg_file_wire), 64'd1);

        // BEQ x1,x2,+16
        dec(32'h00208863);
        check("beq_imm",    64'(bus.imm_o), 64'h10);
        check("beq_single", bus.Single_Instruction_o, 64'h1 << 4);
        check("beq_typ",    64'(bus.INST_typ_o), 64'h08);
        check("beq_amt",    64'(bus.operand_amt_o), 64'h7);
        exe(32'd7, 32'd7, 32'h100);
        check("beq_t_br",   64'(bus.branch_inst_wire), 64'd1);
        check("beq_t_alu1", 64'(bus.alu_result_1), 64'd1);
        check("beq_t_alu2", 64'(bus.alu_result_2), 64'h110);
        check("beq_t_wr",   64'(bus.write_reg_file_wire), 64'd0);
        exe(32'd7, 32'd8, 32'h100);
        check("beq_n_br",   64'(bus.branch_inst_wire), 64'd0);
        check("beq_n_alu1", 64'(bus.alu_result_1), 64'd0);
        check("beq_n_alu2", 64'(bus.alu_result_2), 64'h110);

        // SRAI x6,x1,4
        dec(32'h4040D313);
        check("srai_single", bus.Single_Instruction_o, 64'h1 << 26);
        exe(32'h80000010, 32'd0, 32'd0);
        check("srai_alu1", 64'(bus.alu_result_1), 64'hF8000001);

        // SLTU x7,x1,x2
        dec(32'h0020B3B3);
        check("sltu_single", bus.Single_Instruction_o, 64'h1 << 31);
        exe(32'd1, 32'hFFFFFFFF, 32'd0);
        check("sltu_alu1", 64'(bus.alu_result_1), 64'd1);

        // LUI x0,0x12345 : writes rd but rd is x0
        dec(32'h12345037);
        check("lui_imm", 64'(bus.imm_o), 64'h12345000);
        check("lui_amt", 64'(bus.operand_amt_o), 64'hC);
        check("lui_typ", 64'(bus.INST_typ_o), 64'h10);
        exe(32'd0, 32'd0, 32'd0);
        check("lui_alu1", 64'(bus.alu_result_1), 64'h12345000);
        check("lui_wr",   64'(bus.write_reg_file_wire), 64'd0);

        // SW x2,-4(x1)
        dec(32'hFE20AE23);
        check("sw_imm",    64'(bus.imm_o), 64'hFFFFFFFC);
        check("sw_typ",    64'(bus.INST_typ_o), 64'h04);
        check("sw_single", bus.Single_Instruction_o, 64'h1 << 17);
        exe(32'h1000, 32'hDEADBEEF, 32'd0);
        check("sw_alu1", 64'(bus.alu_result_1), 64'hFFC);
        check("sw_alu2", 64'(bus.alu_result_2), 64'hDEADBEEF);
        check("sw_wr",   64'(bus.write_reg_file_wire), 64'd0);

        // JAL x1,-8
        dec(32'hFF9FF0EF);
        check("jal_imm", 64'(bus.imm_o), 64'hFFFFFFF8);
        check("jal_typ", 64'(bus.INST_typ_o), 64'h20);
        exe(32'd0, 32'd0, 32'h300);
        check("jal_alu1", 64'(bus.alu_result_1), 64'h304);
        check("jal_alu2", 64'(bus.alu_result_2), 64'h2F8);
        check("jal_jmp",  64'(bus.jump_inst_wire), 64'd1);

        // JALR x1,8(x2)
        dec(32'h008100E7);
        check("jalr_rd",     64'(bus.rd_o), 64'd1);
        check("jalr_rs1",    64'(bus.rs1_o), 64'd2);
        check("jalr_single", bus.Single_Instruction_o, 64'h1 << 3);
        exe(32'h1001, 32'd0, 32'h200);
        check("jalr_alu1", 64'(bus.alu_result_1), 64'h204);
        check("jalr_alu2", 64'(bus.alu_result_2), 64'h1008);
        check("jalr_jmp",  64'(bus.jump_inst_wire), 64'd1);
        check("jalr_wr",   64'(bus.write_reg_file_wire), 64'd1);

        // Hold: inputs move while disabled, outputs must not
        bus.i_en = 1'b0;
        bus.instruction = 32'hFFD08293;
        bus.operand1_pi = 32'd55;
        repeat (3) step();
        check("hold_alu1",   64'(bus.alu_result_1), 64'h204);
        check("hold_alu2",   64'(bus.alu_result_2), 64'h1008);
        check("hold_jmp",    64'(bus.jump_inst_wire), 64'd1);
        check("hold_single", bus.Single_Instruction_o, 64'h1 << 3);
        check("hold_rd",     64'(bus.rd_o), 64'd1);
        bus.i_en = 1'b1;

        // Illegal opcode
        dec(32'hFFFFFFFF);
        check("ill_typ",    64'(bus.INST_typ_o), 64'h40);
        check("ill_single", bus.Single_Instruction_o, 64'h0);
        check("ill_amt",    64'(bus.operand_amt_o), 64'h0);
        exe(32'd1, 32'd2, 32'd3);
        check("ill_alu1", 64'(bus.alu_result_1), 64'h0);
        check("ill_alu2", 64'(bus.alu_result_2), 64'h0);
        check("ill_jmp",  64'(bus.jump_inst_wire), 64'd0);
        check("ill_wr",   64'(bus.write_reg_file_wire), 64'd0);

        // MUL x5,x1,x2 and DIV x5,x1,x2
`ifdef RV_M_EXT_EN
        dec(32'h022082B3);
        check("mul_single", bus.Single_Instruction_o, 64'h1 << 40);
        check("mul_typ",    64'(bus.INST_typ_o), 64'h01);
        exe(32'd7, 32'hFFFFFFFD, 32'd0);
        check("mul_alu1", 64'(bus.alu_result_1), 64'hFFFFFFEB);
        dec(32'h0220C2B3);
        check("div_single", bus.Single_Instruction_o, 64'h1 << 44);
        exe(32'h80000000, 32'hFFFFFFFF, 32'd0);
        check("div_ovf", 64'(bus.alu_result_1), 64'h80000000);
        exe(32'd5, 32'd0, 32'd0);
        check("div_zero", 64'(bus.alu_result_1), 64'hFFFFFFFF);
`else
        dec(32'h022082B3);
        check("mul_ill_typ",    64'(bus.INST_typ_o), 64'h40);
        check("mul_ill_single", bus.Single_Instruction_o, 64'h0);
        exe(32'd7, 32'hFFFFFFFD, 32'd0);
        check("mul_ill_alu1", 64'(bus.alu_result_1), 64'h0);
        check("mul_ill_wr",   64'(bus.write_reg_file_wire), 64'd0);
`endif

        // Reset mid-cycle with ADDI in flight clears outputs without a clock edge
        dec(32'hFFD08293);
        exe(32'd10, 32'd0, 32'd0);
        check("pre_rst_alu1", 64'(bus.alu_result_1), 64'd7);
        #3;
        rst = 1'b1;
        #1;
        check("arst_alu1",   64'(bus.alu_result_1), 64'h0);
        check("arst_wr",     64'(bus.write_reg_file_wire), 64'h0);
        check("arst_rd",     64'(bus.rd_o), 64'h0);
        check("arst_imm",    64'(bus.imm_o), 64'h0);
        check("arst_single", bus.Single_Instruction_o, 64'h0);
        check("arst_typ",    64'(bus.INST_typ_o), 64'h0);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32_decode_execute_stage.md
Name:
rv32_decode_execute_stage

Overview:
- Two-stage RV32I front end: decode stage followed by execute stage.
- Decode stage registers the instruction fields and a one-hot instruction identifier.
- Execute stage registers the ALU, branch and jump results computed from the decoded fields plus externally supplied register operands and PC.
- Sits between the fetch/register-file read logic and the memory/writeback stages of the core.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  stage enable; both stages hold their state when low.
- instruction  in  32  raw instruction word.
- operand1_pi  in  32  rs1 value, aligned with the decoded instruction (one cycle after `instruction`).
- operand2_pi  in  32  rs2 value, same alignment as operand1_pi.
- pc_i  in  32  PC of the decoded instruction, same alignment as operand1_pi.
- rd_o, rs1_o, rs2_o  out  5 each  decoded register indices.
- fun3_o  out  3  instruction[14:12].
- fun7_o  out  7  instruction[31:25].
- opcode_o  out  7  instruction[6:0].
- imm_o  out  32  sign-extended immediate.
- Single_Instruction_o  out  64  one-hot instruction ID.
- INST_typ_o  out  7  one-hot format.
- operand_amt_o  out  4  operand-usage mask.
- alu_result_1  out  32  primary result.
- alu_result_2  out  32  secondary result.
- branch_inst_wire  out  1  conditional branch taken.
- jump_inst_wire  out  1  JAL/JALR.
- write_reg_file_wire  out  1  writes rd, and rd is not x0.

Behaviour:
Reset and enable:
- i_rst=1 asynchronously clears every register and output to 0.
- Reset asserted mid-operation discards in-flight instructions in both stages.
- i_en=0 freezes both stages, including their outputs.

Decode stage (registered at the edge where i_en=1):
- Field outputs (rd, rs1, rs2, fun3, fun7, opcode) are valid 1 cycle after `instruction` is sampled.
- Immediates are built per format, sign-extended from instruction[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type: 0
- INST_typ_o bit assignments: bit0 R, bit1 I (including loads, JALR, FENCE, SYSTEM), bit2 S, bit3 B, bit4 U, bit5 J, bit6 illegal/unknown opcode.
- operand_amt_o bit assignments: bit0 uses rs1, bit1 uses rs2, bit2 uses imm, bit3 writes rd.
- Single_Instruction_o, exactly one bit set for a legal instruction:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR
  - 4-9 BEQ, BNE, BLT, BGE, BLTU, BGEU
  - 10-14 LB, LH, LW, LBU, LHU
  - 15-17 SB, SH, SW
  - 18-26 ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - 27-36 ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - 37 FENCE, 38 ECALL, 39 EBREAK
  - 40-63 reserved, always 0
- Illegal encodings (including bad funct7 on R-type or shift-immediate): Single_Instruction_o is all zero and INST_typ_o[6]=1.

Execute stage (registered one cycle after decode, i.e. 2 cycles after `instruction`):
- Inputs used: the decoded fields together with operand1_pi, operand2_pi and pc_i sampled at that edge.
- ALU/OP-IMM:
  - alu_result_1 = result; alu_result_2 = 0.
  - Shifts use amount [4:0]; SRA/SRAI are arithmetic.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - All arithmetic wraps modulo 2^32.
- LUI: result_1 = imm.
- AUIPC: result_1 = pc + imm.
- Loads: result_1 = operand1 + imm (effective address); result_2 = 0.
- Stores: result_1 = operand1 + imm; result_2 = operand2 (store data).
- Branches:
  - result_1 = 1 if the condition holds, else 0; result_2 = pc + imm.
  - branch_inst_wire = condition holds.
- JAL: result_1 = pc + 4; result_2 = pc + imm; jump_inst_wire = 1.
- JALR: result_1 = pc + 4; result_2 = (operand1 + imm) & ~1; jump_inst_wire = 1.
- write_reg_file_wire = operand_amt bit3 AND rd != 0.
- FENCE, ECALL, EBREAK and illegal instructions: all execute outputs are 0.

Optional Feature:
RV_M_EXT_EN
- Defined:
  - Decode recognises MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (opcode 0110011, funct7 0000001) as Single_Instruction_o bits 40-47.
  - Execute computes them combinationally in the same single cycle.
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Undefined: these encodings are illegal (INST_typ_o[6]=1, Single_Instruction_o all zero).

Test Plan:
- Reset: assert i_rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
- ADDI x5,x1,-3 (0xFFD08293), operand1=10 -> decode after 1 cycle:
  - rd=5, imm=0xFFFFFFFD, Single_Instruction bit18, INST_typ bit1, operand_amt=0b1101.
  - After 2 cycles: alu_result_1=7, write_reg_file_wire=1.
- SUB x3,x1,x2 (0x402081B3), op1=5, op2=9 -> alu_result_1=0xFFFFFFFC, Single_Instruction bit28.
- BEQ x1,x2,+16 (0x00208863), pc=0x100:
  - op1=op2=7 -> branch_inst_wire=1, alu_result_2=0x110.
  - op2=8 -> branch_inst_wire=0.
- JALR x1,8(x2) (0x008100E7), pc=0x200, op1=0x1001 -> alu_result_1=0x204, alu_result_2=0x1008, jump_inst_wire=1.
- Hold and illegal: drive i_en=0 for 3 cycles -> outputs unchanged; instruction 0xFFFFFFFF -> INST_typ_o=0x40, Single_Instruction_o=0, write_reg_file_wire=0.
